// File: rtl/grad_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : grad_pkg
//  Description : Shared types and constants for the Sobel gradient stage:
//                frame-sequencer state encoding, error-flag bit indices and
//                the default image geometry also used by the gradient filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package grad_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sticky error flag bit indices
    localparam int ERR_SPURIOUS_RES  = 0;
    localparam int ERR_START_BUSY    = 1;
    localparam int ERR_DRAIN_TIMEOUT = 2;
    localparam int ERR_W             = 3;

    // Default geometry shared with the gradient filter
    localparam int IMG_W_DEFAULT  = 510;
    localparam int IMG_H_DEFAULT  = 636;
    localparam int KERNEL_DEFAULT = 3;

    // Width of the row/column position outputs
    localparam int POS_W = 10;

    // A window is interior once both coordinates have seen a full kernel
    function automatic logic is_interior(input logic [POS_W-1:0] row,
                                         input logic [POS_W-1:0] col,
                                         input int               kernel);
        return (row >= POS_W'(kernel - 1)) && (col >= POS_W'(kernel - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/grad_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : grad_credit_counter
//  Description : Saturating up/down credit counter. Resets full (MAX).
//                take consumes a credit, give returns one; both together
//                leave the count unchanged. Never wraps at 0 or MAX.
//  Ports       : clk, rst_n (async, active-low)
//                i_take  - consume one credit
//                i_give  - return one credit
//                o_avail - at least one credit left
//                o_count - current credit count
//  Revision    : 1.0 - initial release
// ============================================================================
module grad_credit_counter #(
    parameter int MAX   = 32,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_take,
    input  logic             i_give,
    output logic             o_avail,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= c_max;
        end else if (i_take && !i_give && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end else if (i_give && !i_take && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_avail = (r_count != '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/grad_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : grad_frame_sequencer
//  Description : Frame-level controller for the Sobel gradient filter.
//                Tracks raster position of accepted pixels, issues the
//                filter's start / data_valid / matrix_clken for interior
//                windows only, credit-limits issue against the downstream
//                result FIFO, counts results back and flags frame done.
//  Ports       : clk, rst_n (async, active-low)
//                i_frame_start - arm a new frame (1-cycle pulse)
//                i_pix_valid / o_pix_ready - upstream pixel handshake
//                o_win_start   - filter start, RUN through DRAIN
//                o_win_valid   - filter data_valid (interior window)
//                o_win_clken   - filter matrix_clken (one per pixel)
//                i_res_valid   - filter result strobe
//                i_fifo_pop    - downstream consumed a result
//                o_cur_row/col - position of the last accepted pixel
//                o_busy, o_frame_done, o_err_flags (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module grad_frame_sequencer
    import grad_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEFAULT,
    parameter int IMG_H    = IMG_H_DEFAULT,
    parameter int KERNEL   = KERNEL_DEFAULT,
    parameter int PIPE_LAT = 23,
    parameter int CREDITS  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_frame_start,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    output logic             o_win_start,
    output logic             o_win_valid,
    output logic             o_win_clken,
    input  logic             i_res_valid,
    input  logic             i_fifo_pop,
    output logic [POS_W-1:0] o_cur_row,
    output logic [POS_W-1:0] o_cur_col,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [ERR_W-1:0] o_err_flags
);

    localparam int CNT_W = $clog2(IMG_W * IMG_H + 1);
    localparam int CR_W  = $clog2(CREDITS + 1);
    localparam int TMO   = PIPE_LAT + CREDITS + 8;
    localparam int TMO_W = $clog2(TMO + 1);

    localparam logic [POS_W-1:0] c_col_last = POS_W'(IMG_W - 1);
    localparam logic [POS_W-1:0] c_row_last = POS_W'(IMG_H - 1);
    localparam logic [POS_W-1:0] c_pos_one  = POS_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [TMO_W-1:0] c_tmo      = TMO_W'(TMO);
    localparam logic [TMO_W-1:0] c_tmo_one  = TMO_W'(1);
    localparam logic [CR_W-1:0]  c_cr_max   = CR_W'(CREDITS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [POS_W-1:0]   r_nrow;          // position of the next pixel to accept
    logic [POS_W-1:0]   r_ncol;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_results;
    logic [TMO_W-1:0]   r_drain_cnt;     // DRAIN cycles since entry / last result
    logic [ERR_W-1:0]   r_err;
    logic               r_win_valid;
    logic               r_win_clken;
    logic [POS_W-1:0]   r_cur_row;
    logic [POS_W-1:0]   r_cur_col;

    logic               w_credit_avail;
    logic [CR_W-1:0]    w_credit_cnt;
    logic               w_next_interior;
    logic               w_pix_ready;
    logic               w_accept;
    logic               w_issue;
    logic               w_last_pix;
    logic               w_arm;
    logic               w_all_back;
    logic               w_res_count;
    logic               w_timeout;

    // Credits are taken at acceptance, the same edge that raises win_valid,
    // so the ready decision for the following pixel already sees the debit.
    grad_credit_counter #(
        .MAX   (CREDITS),
        .CNT_W (CR_W)
    ) u_credit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_take  (w_issue),
        .i_give  (i_fifo_pop),
        .o_avail (w_credit_avail),
        .o_count (w_credit_cnt)
    );

    assign w_next_interior = is_interior(r_nrow, r_ncol, KERNEL);
    assign w_pix_ready     = (r_state == ST_RUN) && (!w_next_interior || w_credit_avail);
    assign w_accept        = i_pix_valid && w_pix_ready;
    assign w_issue         = w_accept && w_next_interior;
    assign w_last_pix      = w_accept && (r_nrow == c_row_last) && (r_ncol == c_col_last);
    assign w_arm           = (r_state == ST_IDLE) && i_frame_start;
    assign w_all_back      = (r_results == r_issued);
    assign w_res_count     = i_res_valid && !w_all_back;
    assign w_timeout       = (r_state == ST_DRAIN) && !w_all_back && !i_res_valid
                             && (r_drain_cnt == c_tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_frame_start)            w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_pix)               w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_all_back || w_timeout)  w_state_nxt = ST_DONE;
            ST_DONE:                                w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    // Raster position, issue outputs and accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nrow      <= '0;
            r_ncol      <= '0;
            r_cur_row   <= '0;
            r_cur_col   <= '0;
            r_win_valid <= 1'b0;
            r_win_clken <= 1'b0;
            r_issued    <= '0;
            r_results   <= '0;
        end else begin
            r_win_clken <= w_accept;
            r_win_valid <= w_issue;
            if (w_arm) begin
                r_nrow    <= '0;
                r_ncol    <= '0;
                r_cur_row <= '0;
                r_cur_col <= '0;
                r_issued  <= '0;
                r_results <= '0;
            end else begin
                if (w_accept) begin
                    r_cur_row <= r_nrow;
                    r_cur_col <= r_ncol;
                    if (r_ncol == c_col_last) begin
                        r_ncol <= '0;
                        r_nrow <= (r_nrow == c_row_last) ? '0 : r_nrow + c_pos_one;
                    end else begin
                        r_ncol <= r_ncol + c_pos_one;
                    end
                end
                if (w_issue) begin
                    r_issued <= r_issued + c_cnt_one;
                end
                if (w_res_count) begin
                    r_results <= r_results + c_cnt_one;
                end
            end
        end
    end

    // Drain watchdog and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
            r_err       <= '0;
        end else begin
            if ((r_state != ST_DRAIN) || i_res_valid) begin
                r_drain_cnt <= '0;
            end else if (r_drain_cnt != c_tmo) begin
                r_drain_cnt <= r_drain_cnt + c_tmo_one;
            end
            if (i_res_valid && w_all_back) begin
                r_err[ERR_SPURIOUS_RES] <= 1'b1;
            end
            if (i_frame_start && (r_state != ST_IDLE)) begin
                r_err[ERR_START_BUSY] <= 1'b1;
            end
            if (w_timeout) begin
                r_err[ERR_DRAIN_TIMEOUT] <= 1'b1;
            end
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                     w_credit_cnt <= c_cr_max);

    assign o_pix_ready  = w_pix_ready;
    assign o_win_start  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_win_valid  = r_win_valid;
    assign o_win_clken  = r_win_clken;
    assign o_cur_row    = r_cur_row;
    assign o_cur_col    = r_cur_col;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = (r_state == ST_DONE);
    assign o_err_flags  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_grad_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grad_frame_sequencer
//  Description : Self-checking bench for grad_frame_sequencer on a 5x4 image
//                with a 3x3 kernel and 4 credits. A pixel-index model predicts
//                ready, issue, position, credits and frame completion; a
//                delay-queue stands in for the filter and a pending-result
//                count stands in for the downstream FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grad_frame_sequencer;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int K    = 3;
    localparam int LAT  = 6;
    localparam int CR   = 4;
    localparam int TMO  = LAT + CR + 8;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - K + 1) * (H - K + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_frame_start = 1'b0;
    logic       i_pix_valid = 1'b0;
    logic       i_res_valid = 1'b0;
    logic       i_fifo_pop = 1'b0;
    logic       o_pix_ready, o_win_start, o_win_valid, o_win_clken;
    logic [9:0] o_cur_row, o_cur_col;
    logic       o_busy, o_frame_done;
    logic [2:0] o_err_flags;

    always #5 clk = ~clk;

    grad_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .KERNEL(K), .PIPE_LAT(LAT), .CREDITS(CR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_frame_start(i_frame_start), .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
        .o_win_start(o_win_start), .o_win_valid(o_win_valid), .o_win_clken(o_win_clken),
        .i_res_valid(i_res_valid), .i_fifo_pop(i_fifo_pop),
        .o_cur_row(o_cur_row), .o_cur_col(o_cur_col),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err_flags(o_err_flags)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // reference model: phase 0 idle, 1 pixels flowing, 2 waiting for results, 3 done
    int         m_phase, m_idx, m_cred, m_issued, m_results;
    logic [2:0] m_err;
    bit         e_clken, e_valid;
    int         e_row, e_col;

    // environment
    int due_q[$];
    int pending, pop_pct, drop_after;
    bit auto_pop, manual_pop, manual_res, loose_done;
    int win_seen, clken_seen, done_seen, first_done_cyc, last_res_cyc, drain_cyc;

    function automatic bit interior(input int idx);
        return ((idx / W) >= K - 1) && ((idx % W) >= K - 1);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_cred = CR; m_issued = 0; m_results = 0; m_err = '0;
        e_clken = 0; e_valid = 0; e_row = 0; e_col = 0;
        due_q.delete(); pending = 0; manual_pop = 0; manual_res = 0;
        win_seen = 0; clken_seen = 0; done_seen = 0; first_done_cyc = 0;
        last_res_cyc = 0; drain_cyc = 0;
    endtask

    // One clock: drive filter/FIFO side, predict, advance, compare.
    task automatic tick();
        bit exp_ready, acc, take, give, all_back, counted, to_drain;
        i_res_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            i_res_valid = 1'b1;
        end
        if (manual_res) i_res_valid = 1'b1;
        manual_res = 0;
        i_fifo_pop = manual_pop || (auto_pop && pending > 0 && $urandom_range(99) < pop_pct);
        manual_pop = 0;
        if (i_fifo_pop && pending > 0) pending--;

        exp_ready = (m_phase == 1) && (!interior(m_idx) || m_cred > 0);
        n_vec++;
        if (o_pix_ready !== exp_ready) begin
            n_err++;
            $display("FAIL pix_ready cyc=%0d got=%b exp=%b", cyc, o_pix_ready, exp_ready);
        end

        acc      = i_pix_valid && exp_ready;
        take     = acc && interior(m_idx);
        give     = i_fifo_pop;
        all_back = (m_results == m_issued);
        counted  = i_res_valid && !all_back;
        to_drain = 0;
        if (i_res_valid && all_back) m_err[0] = 1'b1;
        if (i_frame_start && m_phase != 0) m_err[1] = 1'b1;
        if (take && !give) m_cred--;
        else if (give && !take && m_cred < CR) m_cred++;
        if (counted) m_results++;
        if (take) m_issued++;
        e_clken = acc;
        e_valid = take;
        if (acc) begin
            e_row = m_idx / W;
            e_col = m_idx % W;
            m_idx++;
        end
        case (m_phase)
            0: if (i_frame_start) begin
                   m_phase = 1; m_idx = 0; m_issued = 0; m_results = 0; e_row = 0; e_col = 0;
               end
            1: if (m_idx == NPIX) begin m_phase = 2; to_drain = 1; end
            2: if (all_back) m_phase = 3;
            default: m_phase = 0;
        endcase

        @(posedge clk);
        #1;
        cyc++;
        if (counted) begin pending++; last_res_cyc = cyc; end
        if (to_drain) drain_cyc = cyc;

        n_vec++;
        if (o_win_clken !== e_clken) begin
            n_err++; $display("FAIL win_clken cyc=%0d got=%b exp=%b", cyc, o_win_clken, e_clken);
        end
        n_vec++;
        if (o_win_valid !== e_valid) begin
            n_err++; $display("FAIL win_valid cyc=%0d got=%b exp=%b", cyc, o_win_valid, e_valid);
        end
        n_vec++;
        if (o_cur_row !== 10'(e_row) || o_cur_col !== 10'(e_col)) begin
            n_err++;
            $display("FAIL cur_pos cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, o_cur_row, o_cur_col, e_row, e_col);
        end
        if (!loose_done) begin
            n_vec++;
            if (o_busy !== (m_phase != 0) || o_frame_done !== (m_phase == 3)
                || o_win_start !== (m_phase == 1 || m_phase == 2)) begin
                n_err++;
                $display("FAIL status cyc=%0d got busy/done/start=%b%b%b exp_phase=%0d",
                         cyc, o_busy, o_frame_done, o_win_start, m_phase);
            end
            n_vec++;
            if (o_err_flags !== m_err) begin
                n_err++; $display("FAIL err_flags cyc=%0d got=%b exp=%b", cyc, o_err_flags, m_err);
            end
        end
        if (o_win_valid) win_seen++;
        if (o_win_clken) clken_seen++;
        if (o_frame_done) begin
            if (done_seen == 0) first_done_cyc = cyc;
            done_seen++;
        end
        if (e_valid && (drop_after == 0 || m_issued <= drop_after)) due_q.push_back(cyc + LAT);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_frame_start = 0; i_pix_valid = 0; i_res_valid = 0; i_fifo_pop = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Arm a frame and stream pixels with the given valid probability until idle.
    task automatic run_frame(input int pv_pct);
        int n;
        i_frame_start = 1; tick(); i_frame_start = 0;
        n = 0;
        while (m_phase != 0 && n < 400) begin
            i_pix_valid = ($urandom_range(99) < pv_pct);
            tick();
            n++;
        end
        i_pix_valid = 0;
        n_vec++;
        if (m_phase != 0) begin
            n_err++; $display("FAIL frame_bound got_phase=%0d exp=0 within 400 cycles", m_phase);
        end
    endtask

    task automatic check_frame(input int wins, input int dones);
        n_vec++;
        if (win_seen != wins) begin
            n_err++; $display("FAIL window_count got=%0d exp=%0d", win_seen, wins);
        end
        n_vec++;
        if (done_seen != dones) begin
            n_err++; $display("FAIL done_count got=%0d exp=%0d", done_seen, dones);
        end
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_pix_ready, o_win_start, o_win_valid, o_win_clken, o_busy, o_frame_done} !== 6'b0) begin
            n_err++; $display("FAIL reset_strobes got=%b exp=000000",
                {o_pix_ready, o_win_start, o_win_valid, o_win_clken, o_busy, o_frame_done});
        end
        n_vec++;
        if (o_cur_row !== 10'd0 || o_cur_col !== 10'd0 || o_err_flags !== 3'b000) begin
            n_err++; $display("FAIL reset_values got row=%0d col=%0d err=%b exp=0", o_cur_row, o_cur_col, o_err_flags);
        end
        apply_reset();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_nominal();
        apply_reset();
        auto_pop = 1; pop_pct = 100;
        run_frame(100);
        check_frame(NWIN, 1);
        n_vec++;
        if (clken_seen != NPIX) begin
            n_err++; $display("FAIL clken_count got=%0d exp=%0d", clken_seen, NPIX);
        end
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        auto_pop = 0;
        i_frame_start = 1; tick(); i_frame_start = 0;
        i_pix_valid = 1;
        for (int i = 0; i < 40; i++) tick();
        n_vec++;
        if (win_seen != CR || clken_seen != 18 || o_pix_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_point got wins=%0d pixels=%0d ready=%b exp wins=4 pixels=18 ready=0",
                              win_seen, clken_seen, o_pix_ready);
        end
        manual_pop = 1;
        for (int i = 0; i < 10; i++) tick();
        n_vec++;
        if (win_seen != CR + 1 || clken_seen != 19) begin
            n_err++; $display("FAIL single_pop got wins=%0d pixels=%0d exp wins=5 pixels=19", win_seen, clken_seen);
        end
        auto_pop = 1; pop_pct = 100;
        n = 0;
        while (m_phase != 0 && n < 200) begin tick(); n++; end
        i_pix_valid = 0;
        check_frame(NWIN, 1);
    endtask

    task automatic test_simultaneous();
        int n;
        apply_reset();
        auto_pop = 0;
        manual_pop = 1;                  // pop while already full
        tick();
        i_frame_start = 1; tick(); i_frame_start = 0;
        i_pix_valid = 1;
        for (int i = 0; i < 40; i++) begin
            if (m_phase == 1 && m_idx == (K - 1) * W + (K - 1)) manual_pop = 1;  // with first issue
            tick();
        end
        n_vec++;
        if (win_seen != CR + 1 || clken_seen != 19) begin
            n_err++; $display("FAIL net_zero got wins=%0d pixels=%0d exp wins=5 pixels=19", win_seen, clken_seen);
        end
        auto_pop = 1; pop_pct = 100;
        n = 0;
        while (m_phase != 0 && n < 200) begin tick(); n++; end
        i_pix_valid = 0;
        check_frame(NWIN, 1);
    endtask

    task automatic test_errors();
        apply_reset();
        manual_res = 1;
        tick(); tick();
        n_vec++;
        if (o_err_flags !== 3'b001) begin
            n_err++; $display("FAIL spurious_res got=%b exp=001", o_err_flags);
        end

        apply_reset();
        auto_pop = 1; pop_pct = 100;
        i_frame_start = 1; tick(); i_frame_start = 0;
        i_pix_valid = 1;
        for (int i = 0; i < 7; i++) tick();
        i_frame_start = 1; tick(); i_frame_start = 0;
        for (int i = 0; i < 200 && m_phase != 0; i++) tick();
        i_pix_valid = 0;
        n_vec++;
        if (o_err_flags !== 3'b010) begin
            n_err++; $display("FAIL start_busy got=%b exp=010", o_err_flags);
        end
        check_frame(NWIN, 1);
    endtask

    task automatic test_drain_timeout();
        int n, quiet;
        apply_reset();
        loose_done = 1; drop_after = NWIN - 1; auto_pop = 1; pop_pct = 100;
        i_frame_start = 1; tick(); i_frame_start = 0;
        i_pix_valid = 1;
        n = 0;
        while (m_phase == 1 && n < 200) begin tick(); n++; end
        i_pix_valid = 0;
        n = 0;
        while (done_seen == 0 && n < 100) begin tick(); n++; end
        n_vec++;
        if (done_seen != 1) begin
            n_err++; $display("FAIL timeout_done got=%0d exp=1 within 100 cycles", done_seen);
        end
        quiet = first_done_cyc - ((last_res_cyc > drain_cyc) ? last_res_cyc : drain_cyc);
        n_vec++;
        if (quiet < TMO + 1 || quiet > TMO + 2) begin
            n_err++; $display("FAIL timeout_len got=%0d exp=%0d..%0d", quiet, TMO + 1, TMO + 2);
        end
        n_vec++;
        if (o_err_flags !== 3'b100) begin
            n_err++; $display("FAIL timeout_err got=%b exp=100", o_err_flags);
        end
        tick();
        n_vec++;
        if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            n_err++; $display("FAIL timeout_idle got busy=%b done=%b exp 0 0", o_busy, o_frame_done);
        end
        loose_done = 0; drop_after = 0;
    endtask

    task automatic test_reset_midframe();
        int n;
        apply_reset();
        auto_pop = 1; pop_pct = 100;
        i_frame_start = 1; tick(); i_frame_start = 0;
        i_pix_valid = 1;
        n = 0;
        while (clken_seen < 14 && n < 100) begin tick(); n++; end
        i_pix_valid = 0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_pix_ready, o_win_start, o_win_valid, o_win_clken, o_busy, o_frame_done} !== 6'b0
            || o_cur_row !== 10'd0 || o_cur_col !== 10'd0 || o_err_flags !== 3'b000) begin
            n_err++; $display("FAIL midframe_reset got strobes=%b row=%0d col=%0d err=%b exp all 0",
                {o_pix_ready, o_win_start, o_win_valid, o_win_clken, o_busy, o_frame_done},
                o_cur_row, o_cur_col, o_err_flags);
        end
        apply_reset();
        tick();
        run_frame(100);
        check_frame(NWIN, 1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            win_seen = 0; done_seen = 0;
            auto_pop = 1;
            pop_pct = $urandom_range(20, 90);
            run_frame($urandom_range(30, 100));
            check_frame(NWIN, 1);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        auto_pop = 0; pop_pct = 100; drop_after = 0; loose_done = 0;
        model_reset();
        test_reset();
        test_nominal();
        test_backpressure();
        test_simultaneous();
        test_errors();
        test_drain_timeout();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
